// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period and parity helper.
// Used by every UART block on the board.
package uart_pkg;

  localparam int CLK_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity bit: makes the total count of ones across data+parity even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty/count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_r;
  logic             empty_r;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic [CW-1:0]    count_next_s;

  assign pop_ok_s  = pop & ~empty_r;
  assign push_ok_s = push & (~full_r | pop_ok_s);

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_next_s = count_r + CW'(1);
    end else if (!push_ok_s && pop_ok_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers (wrap naturally since DEPTH is a power of two) and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == {CW{1'b0}});
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding an 8N1 serializer, frames sent back-to-back.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1 framing).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
  parameter  int DEPTH       = 16,
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int TW          = $clog2(CLK_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          block,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          tx
);

  uart_state_e   state_r;
  logic [TW-1:0] timer_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          active_r;
  logic          pop_s;
  logic          bit_end_s;
  logic [7:0]    fifo_dout_s;
  logic          fifo_empty_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop_s),
    .din   (wr_data),
    .dout  (fifo_dout_s),
    .full  (full),
    .empty (fifo_empty_s),
    .count (count)
  );

  // block only matters here: a frame already under way is never interrupted.
  assign pop_s     = (state_r == ST_IDLE) & ~fifo_empty_s & ~block;
  assign bit_end_s = (timer_r == TW'(CLK_PER_BIT - 1));

  // Frame sequencer, bit timer and the tx output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      timer_r   <= {TW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      active_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          timer_r   <= {TW{1'b0}};
          bit_idx_r <= 3'd0;
          if (pop_s) begin
            shift_r  <= fifo_dout_s;
            state_r  <= ST_START;
            tx_r     <= 1'b0;
            active_r <= 1'b1;
          end else begin
            tx_r     <= 1'b1;
            active_r <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            timer_r <= {TW{1'b0}};
            state_r <= ST_DATA;
            tx_r    <= shift_r[0];
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            timer_r <= {TW{1'b0}};
            if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_r <= ST_PARITY;
              tx_r    <= even_parity(shift_r);
`else
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[bit_idx_r + 3'd1];
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_s) begin
            timer_r <= {TW{1'b0}};
            state_r <= ST_STOP;
            tx_r    <= 1'b1;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_end_s) begin
            timer_r  <= {TW{1'b0}};
            state_r  <= ST_IDLE;
            active_r <= 1'b0;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
          tx_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_IDLE;
          timer_r  <= {TW{1'b0}};
          tx_r     <= 1'b1;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign empty = fifo_empty_s;
  assign busy  = active_r | ~fifo_empty_s;
  assign tx    = tx_r;

endmodule
